// File: rtl/regview_renderer.sv
// Register-dump text renderer: snapshots R0-RF over the debug port, then paints
// 136 pixel rows (heading plus one text line per register) into VRAM port A.
module regview_renderer #(
    parameter int BASE_ROW = 0,
    parameter int COL0     = 0
) (
    input  logic         PCLK,
    input  logic         RST,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [3:0]   dbg_ra,
    input  logic [15:0]  dbg_rd,
    output logic         vram_we,
    output logic [8:0]   vram_addr,
    output logic [639:0] vram_wdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SNAP   = 2'd1;
    localparam logic [1:0] ST_RENDER = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Character codes: 0..15 are the hex digits themselves.
    localparam logic [4:0] CH_E  = 5'd14;
    localparam logic [4:0] CH_R  = 5'd16;
    localparam logic [4:0] CH_G  = 5'd17;
    localparam logic [4:0] CH_I  = 5'd18;
    localparam logic [4:0] CH_S  = 5'd19;
    localparam logic [4:0] CH_T  = 5'd20;
    localparam logic [4:0] CH_SP = 5'd21;

    localparam int SHIFT = 8 * COL0;

    logic [1:0]   state_reg;
    logic         pending_reg;
    logic [255:0] snap_reg;
    logic [4:0]   k_reg;
    logic [7:0]   r_reg;
    logic         done_reg;
    logic         we_reg;
    logic [8:0]   addr_reg;
    logic [639:0] wdata_reg;

    logic [7:0]   row_idx;
    logic [4:0]   line;
    logic [2:0]   glyph_g;
    logic [3:0]   reg_sel;
    logic [15:0]  reg_val;
    logic [3:0]   snap_idx;
    logic [4:0]   cell_code [9];
    logic [7:0]   cell_glyph [9];
    logic [71:0]  text_bits;
    logic [639:0] row_next;
    logic [8:0]   addr_next;

    function automatic logic [7:0] glyph_row(input logic [4:0] code, input logic [2:0] g);
        logic [63:0] bits;
        case (code)
            5'd0:    bits = 64'h3C666E7666663C00;
            5'd1:    bits = 64'h1838181818187E00;
            5'd2:    bits = 64'h3C66060C30607E00;
            5'd3:    bits = 64'h3C66061C06663C00;
            5'd4:    bits = 64'h0C1C3C6C7E0C0C00;
            5'd5:    bits = 64'h7E607C0606663C00;
            5'd6:    bits = 64'h3C607C6666663C00;
            5'd7:    bits = 64'h7E060C1830303000;
            5'd8:    bits = 64'h3C66663C66663C00;
            5'd9:    bits = 64'h3C66663E060C3800;
            5'd10:   bits = 64'h183C66667E666600;
            5'd11:   bits = 64'h7C66667C66667C00;
            5'd12:   bits = 64'h3C66606060663C00;
            5'd13:   bits = 64'h786C6666666C7800;
            5'd14:   bits = 64'h7E60607C60607E00;
            5'd15:   bits = 64'h7E60607C60606000;
            CH_R:    bits = 64'h7C66667C786C6600;
            CH_G:    bits = 64'h3C66606E66663C00;
            CH_I:    bits = 64'h3C18181818183C00;
            CH_S:    bits = 64'h3C66603C06663C00;
            CH_T:    bits = 64'h7E18181818181800;
            default: bits = 64'h0;
        endcase
        // Glyph row 0 sits in the top byte.
        return bits[{~g, 3'b000} +: 8];
    endfunction

    // The row being loaded into the output registers at the coming edge.
    assign row_idx  = (state_reg == ST_RENDER) ? r_reg + 8'd1 : 8'd0;
    assign line     = row_idx[7:3];
    assign glyph_g  = row_idx[2:0];
    assign reg_sel  = line[3:0] - 4'd1;
    assign reg_val  = snap_reg[{reg_sel, 4'b0000} +: 16];
    assign snap_idx = k_reg[3:0] - 4'd1;

    always_comb begin
        for (int c = 0; c < 9; c++) cell_code[c] = CH_SP;
        if (line == 5'd0) begin
            cell_code[0] = CH_R;
            cell_code[1] = CH_E;
            cell_code[2] = CH_G;
            cell_code[3] = CH_I;
            cell_code[4] = CH_S;
            cell_code[5] = CH_T;
            cell_code[6] = CH_E;
            cell_code[7] = CH_R;
            cell_code[8] = CH_S;
        end else begin
            cell_code[0] = CH_R;
            cell_code[1] = {1'b0, reg_sel};
            cell_code[3] = {1'b0, reg_val[15:12]};
            cell_code[4] = {1'b0, reg_val[11:8]};
            cell_code[5] = {1'b0, reg_val[7:4]};
            cell_code[6] = {1'b0, reg_val[3:0]};
        end
    end

    genvar gi, gk;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign cell_glyph[gi] = glyph_row(cell_code[gi], glyph_g);
            for (gk = 0; gk < 8; gk++) begin : g_px
                assign text_bits[8*gi+gk] = cell_glyph[gi][7-gk];
            end
        end
    endgenerate

    assign row_next  = 640'(text_bits) << SHIFT;
    assign addr_next = 9'(BASE_ROW) + {1'b0, row_idx};

    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
            snap_reg    <= '0;
            k_reg       <= '0;
            r_reg       <= '0;
            done_reg    <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start && state_reg != ST_IDLE) pending_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SNAP;
                        k_reg     <= '0;
                    end
                end
                ST_SNAP: begin
                    if (k_reg != 5'd0) snap_reg[{snap_idx, 4'b0000} +: 16] <= dbg_rd;
                    if (k_reg == 5'd16) begin
                        state_reg <= ST_RENDER;
                        r_reg     <= '0;
                        we_reg    <= 1'b1;
                        addr_reg  <= addr_next;
                        wdata_reg <= row_next;
                    end else begin
                        k_reg <= k_reg + 5'd1;
                    end
                end
                ST_RENDER: begin
                    if (r_reg == 8'd135) begin
                        state_reg <= ST_DONE;
                        we_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        r_reg     <= r_reg + 8'd1;
                        addr_reg  <= addr_next;
                        wdata_reg <= row_next;
                    end
                end
                ST_DONE: begin
                    // A request arriving in this very cycle still chains a re-run.
                    if (pending_reg || start) begin
                        state_reg   <= ST_SNAP;
                        k_reg       <= '0;
                        pending_reg <= 1'b0;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign dbg_ra     = (state_reg == ST_SNAP && !k_reg[4]) ? k_reg[3:0] : 4'd0;
    assign vram_we    = we_reg;
    assign vram_addr  = addr_reg;
    assign vram_wdata = wdata_reg;

endmodule

// File: tb/tb_regview_renderer.sv
// Directed bench for regview_renderer: two instances (default placement and an
// offset one) read a shared register-file model; VRAM writes are captured per instance.
module tb_regview_renderer;

    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic RST = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic busy0, done0, we0, busy1, done1, we1;
    logic [3:0] dbg_ra0, dbg_ra1;
    logic [15:0] dbg_rd0, dbg_rd1;
    logic [8:0] addr0, addr1;
    logic [639:0] wdata0, wdata1;

    logic [15:0] rf [16];
    always @(posedge PCLK) begin
        dbg_rd0 <= rf[dbg_ra0];
        dbg_rd1 <= rf[dbg_ra1];
    end

    regview_renderer u_dut0 (
        .PCLK(PCLK), .RST(RST), .start(start0), .busy(busy0), .done(done0),
        .dbg_ra(dbg_ra0), .dbg_rd(dbg_rd0), .vram_we(we0), .vram_addr(addr0),
        .vram_wdata(wdata0)
    );

    regview_renderer #(.BASE_ROW(100), .COL0(10)) u_dut1 (
        .PCLK(PCLK), .RST(RST), .start(start1), .busy(busy1), .done(done1),
        .dbg_ra(dbg_ra1), .dbg_rd(dbg_rd1), .vram_we(we1), .vram_addr(addr1),
        .vram_wdata(wdata1)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    logic [639:0] img0 [512];
    logic [639:0] img1 [512];
    int wr_addr0[$], wr_addr1[$], done_cyc0[$], done_cyc1[$];
    int busy_low0 = 0;

    always @(negedge PCLK) begin
        if (we0) begin
            img0[addr0] = wdata0;
            wr_addr0.push_back(int'(addr0));
        end
        if (we1) begin
            img1[addr1] = wdata1;
            wr_addr1.push_back(int'(addr1));
        end
        if (done0) done_cyc0.push_back(cyc);
        if (done1) done_cyc1.push_back(cyc);
        if (!busy0) busy_low0++;
    end

    function automatic logic [63:0] font(input byte ch);
        case (ch)
            "0": return 64'h3C666E7666663C00;
            "1": return 64'h1838181818187E00;
            "2": return 64'h3C66060C30607E00;
            "3": return 64'h3C66061C06663C00;
            "4": return 64'h0C1C3C6C7E0C0C00;
            "5": return 64'h7E607C0606663C00;
            "6": return 64'h3C607C6666663C00;
            "7": return 64'h7E060C1830303000;
            "8": return 64'h3C66663C66663C00;
            "9": return 64'h3C66663E060C3800;
            "A", "a": return 64'h183C66667E666600;
            "B", "b": return 64'h7C66667C66667C00;
            "C", "c": return 64'h3C66606060663C00;
            "D", "d": return 64'h786C6666666C7800;
            "E", "e": return 64'h7E60607C60607E00;
            "F", "f": return 64'h7E60607C60606000;
            "R": return 64'h7C66667C786C6600;
            "G": return 64'h3C66606E66663C00;
            "I": return 64'h3C18181818183C00;
            "S": return 64'h3C66603C06663C00;
            "T": return 64'h7E18181818181800;
            " ": return 64'h0;
            default: return 64'hFFFFFFFFFFFFFFFF;
        endcase
    endfunction

    function automatic logic [639:0] gold_row(input string s, input int g, input int col0);
        logic [639:0] row;
        logic [63:0] f;
        row = '0;
        for (int c = 0; c < 9; c++) begin
            f = font(s[c]);
            for (int k = 0; k < 8; k++) row[8*(col0+c)+k] = f[8*(7-g)+7-k];
        end
        return row;
    endfunction

    task automatic step();
        @(negedge PCLK);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr0.delete(); wr_addr1.delete();
        done_cyc0.delete(); done_cyc1.delete();
    endtask

    task automatic pulse_start0(output int t);
        start0 = 1'b1;
        t = cyc;
        step();
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done_cyc0.size() >= n) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_idle0(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (!busy0) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        int errs;
        RST = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) step();
        tests_run++;
        if ({busy0, done0, we0} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {busy0, done0, we0});
        end
        tests_run++;
        if (dbg_ra0 !== 4'd0 || addr0 !== 9'd0 || wdata0 !== '0) begin
            tests_failed++; $display("FAIL reset_data: dbg_ra=%0d addr=%0d wdata_nz=%0b expected 0", dbg_ra0, addr0, |wdata0);
        end
        tests_run++;
        if ({busy1, done1, we1} !== 3'b000 || addr1 !== 9'd0) begin
            tests_failed++; $display("FAIL reset_dut1: busy/done/we=%b addr=%0d expected 000/0", {busy1, done1, we1}, addr1);
        end
        RST = 1'b0;
        clear_logs();
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({busy0, done0, we0} !== 3'b000 || dbg_ra0 !== 4'd0) errs++;
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++; $display("FAIL idle_quiet: %0d active cycles expected 0", errs);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        int t, errs, hi_errs, img_errs;
        bit ok;
        string s;
        logic [639:0] hi_mask;
        for (int k = 0; k < 16; k++) rf[k] = 16'h1111 * k[15:0];
        clear_logs();
        pulse_start0(t);
        wait_done0(1, 300, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL basic_done_timeout: got no done, expected one within 300 cycles");
            return;
        end
        tests_run++;
        if (done_cyc0[0] - t !== 154) begin
            tests_failed++; $display("FAIL basic_latency: %0d expected 154", done_cyc0[0] - t);
        end
        tests_run++;
        if (wr_addr0.size() !== 136) begin
            tests_failed++; $display("FAIL basic_wr_count: %0d expected 136", wr_addr0.size());
        end
        errs = 0;
        foreach (wr_addr0[i]) if (wr_addr0[i] !== i) errs++;
        tests_run++;
        if (errs !== 0) begin
            tests_failed++; $display("FAIL basic_addr_seq: %0d bad addresses expected 0", errs);
        end
        for (int g = 0; g < 8; g++) begin
            tests_run++;
            if (img0[48+g] !== gold_row("R5 5555  ", g, 0)) begin
                tests_failed++; $display("FAIL basic_R5_row%0d: got %h expected %h", g, img0[48+g][71:0], gold_row("R5 5555  ", g, 0) >> 0);
            end
        end
        hi_mask = ~640'(72'hFFFFFFFFFFFFFFFFFF);
        hi_errs = 0;
        img_errs = 0;
        for (int r = 0; r < 136; r++) begin
            if ((img0[r] & hi_mask) !== '0) hi_errs++;
            s = (r < 8) ? "REGISTERS" : $sformatf("R%0h %04h  ", 4'(r/8 - 1), rf[r/8 - 1]);
            if (img0[r] !== gold_row(s, r % 8, 0)) img_errs++;
        end
        tests_run++;
        if (hi_errs !== 0) begin
            tests_failed++; $display("FAIL basic_high_bits: %0d rows nonzero above bit 71 expected 0", hi_errs);
        end
        tests_run++;
        if (img_errs !== 0) begin
            tests_failed++; $display("FAIL basic_full_image: %0d rows differ expected 0", img_errs);
        end
        repeat (5) step();
        tests_run++;
        if (done_cyc0.size() !== 1 || busy0 !== 1'b0) begin
            tests_failed++; $display("FAIL basic_return_idle: dones=%0d busy=%b expected 1/0", done_cyc0.size(), busy0);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_col0_base();
        int errs;
        bit ok;
        rf[15] = 16'hBEEF;
        clear_logs();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (done_cyc1.size() >= 1) ok = 1'b1;
            else step();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL col0_done_timeout: got no done, expected one within 300 cycles");
            return;
        end
        errs = 0;
        foreach (wr_addr1[i]) if (wr_addr1[i] !== 100 + i) errs++;
        tests_run++;
        if (wr_addr1.size() !== 136 || errs !== 0) begin
            tests_failed++; $display("FAIL col0_addr_seq: count=%0d bad=%0d expected 136/0", wr_addr1.size(), errs);
        end
        tests_run++;
        if (img1[228] !== gold_row("RF BEEF  ", 0, 10)) begin
            tests_failed++; $display("FAIL col0_row228: got %h expected %h", img1[228][159:0], gold_row("RF BEEF  ", 0, 10) >> 0);
        end
        tests_run++;
        if (img1[103] !== gold_row("REGISTERS", 3, 10)) begin
            tests_failed++; $display("FAIL col0_heading_row3: got %h expected %h", img1[103][159:0], gold_row("REGISTERS", 3, 10) >> 0);
        end
        $display("[TB] test_col0_base done");
    endtask

    task automatic test_back_to_back();
        int t, lows;
        bit ok;
        clear_logs();
        start0 = 1'b1;
        t = cyc;
        busy_low0 = 0;
        wait_done0(3, 700, ok);
        lows = busy_low0;
        start0 = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL b2b_timeout: %0d dones expected 3", done_cyc0.size());
            return;
        end
        tests_run++;
        if (done_cyc0[0] - t !== 154 || done_cyc0[1] - done_cyc0[0] !== 154 || done_cyc0[2] - done_cyc0[1] !== 154) begin
            tests_failed++; $display("FAIL b2b_period: %0d/%0d/%0d expected 154/154/154",
                done_cyc0[0] - t, done_cyc0[1] - done_cyc0[0], done_cyc0[2] - done_cyc0[1]);
        end
        tests_run++;
        if (lows !== 0) begin
            tests_failed++; $display("FAIL b2b_busy_gap: busy low %0d cycles expected 0", lows);
        end
        tests_run++;
        if (wr_addr0.size() !== 408) begin
            tests_failed++; $display("FAIL b2b_writes: %0d expected 408", wr_addr0.size());
        end
        wait_idle0(400, ok);
        tests_run++;
        if (!ok || done_cyc0.size() !== 4) begin
            tests_failed++; $display("FAIL b2b_tail_run: idle=%b dones=%0d expected 1/4", ok, done_cyc0.size());
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_coherence();
        int t, errs;
        bit ok;
        rf[3] = 16'h3333;
        clear_logs();
        pulse_start0(t);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (we0) ok = 1'b1;
            else step();
        end
        rf[3] = 16'hA5C3;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_done0(1, 300, ok);
        errs = 0;
        for (int g = 0; g < 8; g++) if (img0[32+g] !== gold_row("R3 3333  ", g, 0)) errs++;
        tests_run++;
        if (!ok || errs !== 0) begin
            tests_failed++; $display("FAIL coh_old_value: done=%b bad_rows=%0d expected 1/0", ok, errs);
        end
        wait_done0(2, 300, ok);
        errs = 0;
        for (int g = 0; g < 8; g++) if (img0[32+g] !== gold_row("R3 A5C3  ", g, 0)) errs++;
        tests_run++;
        if (!ok || errs !== 0) begin
            tests_failed++; $display("FAIL coh_new_value: done=%b bad_rows=%0d expected 1/0", ok, errs);
        end
        tests_run++;
        if (ok && done_cyc0[1] - done_cyc0[0] !== 154) begin
            tests_failed++; $display("FAIL coh_rerun_gap: %0d expected 154", done_cyc0[1] - done_cyc0[0]);
        end
        wait_idle0(50, ok);
        $display("[TB] test_coherence done");
    endtask

    task automatic test_reset_mid();
        int t;
        bit ok;
        clear_logs();
        pulse_start0(t);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (we0 && addr0 == 9'd50) ok = 1'b1;
            else step();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL rmid_reach_row50: not reached expected within 100 cycles");
        end
        RST = 1'b1;
        step();
        tests_run++;
        if ({we0, busy0, done0} !== 3'b000) begin
            tests_failed++; $display("FAIL rmid_abort: we/busy/done=%b expected 000", {we0, busy0, done0});
        end
        RST = 1'b0;
        clear_logs();
        repeat (20) step();
        tests_run++;
        if (wr_addr0.size() !== 0 || done_cyc0.size() !== 0) begin
            tests_failed++; $display("FAIL rmid_quiet: writes=%0d dones=%0d expected 0/0", wr_addr0.size(), done_cyc0.size());
        end
        pulse_start0(t);
        wait_done0(1, 300, ok);
        tests_run++;
        if (!ok || done_cyc0[0] - t !== 154 || wr_addr0.size() !== 136) begin
            tests_failed++; $display("FAIL rmid_rerun: done=%b latency=%0d writes=%0d expected 1/154/136",
                ok, ok ? done_cyc0[0] - t : -1, wr_addr0.size());
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rf[k] = 16'h0;
        test_reset();
        test_basic();
        test_col0_base();
        test_back_to_back();
        test_coherence();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regview_renderer.md
Name: regview_renderer

Overview:
- Renders the 16 architectural registers as text into VRAM port A, giving the VGA path a live register dump.
- Sits between the register file (via a dedicated debug read port) and VRAM (via its read/write port).
- On each start request it takes a coherent snapshot of R0–RF, then writes 136 full 640-bit pixel rows.
- Rows cover 17 text lines: a "REGISTERS" heading plus one line per register.

Parameters:
- BASE_ROW, 0: VRAM row address of the first pixel row. Legal range 0..376, so that BASE_ROW+135 ≤ 511.
- COL0, 0: character column of the left edge of the text. Legal range 0..71; each column is 8 pixels.

Ports:
- PCLK  input  1  pipeline clock; all logic is on its rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  request a refresh; level-sampled each cycle
- busy  output  1  high while a snapshot or render is in progress
- done  output  1  one-cycle pulse after the last VRAM write
- dbg_ra  output  4  register-file debug read address
- dbg_rd  input  16  register-file debug read data; valid one cycle after dbg_ra
- vram_we  output  1  VRAM row write strobe
- vram_addr  output  9  VRAM row address
- vram_wdata  output  640  full pixel row; bit x = pixel x, bit 0 = leftmost; 1 = lit

Behaviour:
- Reset (RST high at a PCLK edge):
  - State goes to IDLE; the pending flag and the 256-bit snapshot buffer clear to 0.
  - busy=0, done=0, vram_we=0, dbg_ra=0, vram_addr=0, vram_wdata=0.
  - Reset mid-snapshot or mid-render aborts immediately; no further writes occur.
- States: IDLE -> SNAP -> RENDER -> DONE -> IDLE, or DONE -> SNAP if pending.
- IDLE: start=1 -> SNAP next cycle, snapshot counter k=0.
- SNAP, 17 cycles:
  - Cycle j (0..15) drives dbg_ra=j.
  - Cycle j+1 captures dbg_rd into snap[j].
  - After the 17th cycle -> RENDER, row counter r=0.
- RENDER, 136 cycles, one row per cycle:
  - vram_we=1, vram_addr=BASE_ROW+r, vram_wdata=row(r), r increments.
  - After r=135 -> DONE.
- DONE, 1 cycle: done=1, vram_we=0.
  - Next state is SNAP if pending (pending clears), otherwise IDLE.
- busy=1 in SNAP, RENDER and DONE. Total latency from start acceptance to done is 154 cycles.
- start outside IDLE sets pending. Multiple requests collapse into one re-run. start during DONE also sets pending.
- Text content, 9 character cells, line L = r/8:
  - L=0: "REGISTERS".
  - L=n (1..16): 'R', hex(n-1), ' ', then the 4 hex digits of snap[n-1], MS nibble first, then 2 spaces.
  - Hex digits use uppercase 0-9 and A-F.
- Pixel mapping:
  - Glyph row g = r%8.
  - Cell c (0..8) places glyph bit (7-k) at pixel 8*(COL0+c)+k.
  - All other bits of vram_wdata are 0.
- Internal 8x8 glyph ROM covers: 0-9, A-F, R, G, I, S, T, space. E is shared with the hex glyph.
  - Row 7 of every glyph is 0.
  - Space is all-zero.
- Snapshot coherence: render uses only the snap[] values; register writes during RENDER do not appear until the next refresh.
- Outside RENDER, vram_we=0. vram_addr and vram_wdata hold their last values (don't-care).

Test Plan:
- RST held high, then released with start=0 -> busy=0, done=0, vram_we=0 indefinitely; no dbg_ra activity beyond 0.
- Regfile preloaded with Rk=16'h1111*k, start pulsed once, BASE_ROW=0, COL0=0:
  - Exactly 136 writes to addresses 0..135, done at cycle 154.
  - Row 8*6+g equals the golden glyph concatenation of "R5 5555  " row g.
  - Bits 72..639 are 0 on every row.
- COL0=10, BASE_ROW=100, R15=16'hBEEF:
  - Writes go to addresses 100..235.
  - Row 228 cells start at pixel 80 and match "RF BEEF  " glyph row 0.
- start held high continuously -> back-to-back refreshes: DONE goes straight to SNAP, one run per 154 cycles, no gaps beyond the DONE cycle.
- Regfile write of R3 during RENDER of a run -> that run shows the old value; the pending re-run shows the new value.
- RST asserted at RENDER row 50 -> vram_we=0 from the next cycle, no done pulse; a subsequent start gives a full 154-cycle run.
